pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter CTRL_W, 16, width of the control word carried down the pipeline.
REQ-002 Parameter NSTAGES, 3, number of post-decode stages (stage 1 = EX, stage NSTAGES = WB); legal range 3..6.
REQ-003 Parameter RW_BIT, 0, index of the reg_write bit inside the control word.
REQ-004 Port clk  input  1  sole clock; all state on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port id_valid  input  1  decode stage holds a real instruction.
REQ-007 Port id_ctrl  input  CTRL_W  decoded control word.
REQ-008 Port id_rs1 / id_rs2 / id_rd  input  5 each  source and destination register indices.
REQ-009 Port id_use_rs1 / id_use_rs2  input  1 each  instruction reads that source.
REQ-010 Port id_is_load  input  1  instruction is a load.
REQ-011 Port ex_branch_taken  input  1  branch/jump resolved taken in stage 1 this cycle.
REQ-012 Port stg_ctrl  output  NSTAGES x CTRL_W  control word per stage.
REQ-013 Port stg_valid / stg_rd  output  NSTAGES x 1 / NSTAGES x 5  valid bit and rd per stage.
REQ-014 Port stall_id  output  1  hold PC and IF/ID register this cycle.
REQ-015 Port flush_id  output  1  clear IF/ID register this cycle.
REQ-016 Port fwd_a / fwd_b  output  $clog2(NSTAGES) each  operand source for stage 1 (0 = register file, k = stage k+1 result).
REQ-017 Port stall_cnt / flush_cnt  output  32 each  event counters.

Function
REQ-018 Without stall or flush, on each edge stage 1 SHALL load the ID inputs (ctrl, valid, rd, rs1, rs2, use flags, is_load) and stage k SHALL load stage k-1.
REQ-019 Load-use hazard SHALL be: id_valid & stg_valid[1] & stage-1 is_load & stg_rd[1]!=0 & ((id_use_rs1 & id_rs1==stg_rd[1]) | (id_use_rs2 & id_rs2==stg_rd[1])); combinational.
REQ-020 On hazard, stall_id SHALL be 1, stage 1 SHALL load a bubble (valid=0, ctrl=0, rd=0), stages 2..NSTAGES SHALL advance normally.
REQ-021 When ex_branch_taken=1, flush_id SHALL be 1 and stage 1 SHALL load a bubble; stages 2..NSTAGES SHALL advance; the branching instruction itself is not squashed.
REQ-022 Flush SHALL take priority: when hazard and ex_branch_taken coincide, stall_id=0, flush_id=1, stall_cnt does not increment.
REQ-023 ex_branch_taken SHALL be ignored when stg_valid[1]=0.
REQ-024 fwd_a SHALL select the lowest k in 2..NSTAGES with stg_valid[k] & stg_ctrl[k][RW_BIT] & stg_rd[k]!=0 & stg_rd[k]==stage-1 rs1 & stage-1 use_rs1, outputting k-1; else 0. fwd_b identical for rs2.
REQ-025 stall_cnt SHALL increment by 1 per cycle with stall_id=1; flush_cnt per cycle with flush_id=1; both wrap at 2^32-1 -> 0.
REQ-026 Bubbles SHALL never generate forwarding, hazards, or branch flushes.

Reset
REQ-027 On reset assertion, all stage registers SHALL clear asynchronously to valid=0, ctrl=0, rd/rs=0, flags=0; counters to 0.
REQ-028 During reset stall_id, flush_id, fwd_a, fwd_b SHALL be 0.
REQ-029 Reset mid-stall SHALL discard the stalled instruction's bubble state; first post-reset edge loads ID inputs normally.

Structure
REQ-030 Package pipe_pkg SHALL hold REG_AW=5, the stage-entry struct (ctrl, valid, rd, rs1, rs2, use flags, is_load), and the forwarding-select typedef.
REQ-031 One sub-module pipe_stage_reg (one stage entry, async reset, load-bubble input) SHALL be instantiated NSTAGES times via generate.

Verification
REQ-032 Plain flow: NSTAGES=3, id ctrl=0x0001 rd=5 valid each cycle -> appears at stg_ctrl[3] exactly 3 edges later, no stall/flush.
REQ-033 Load-use: load rd=7 then add rs1=7 -> stall_id=1 one cycle, stage 1 bubble, stall_cnt=1, then fwd_a=2 (from WB) when add reaches EX.
REQ-034 Forward priority: writes to rd=3 in stages 2 and 3, EX reads rs2=3 -> fwd_b=1; rd=0 in both -> fwd_b=0.
REQ-035 Branch+hazard same cycle: ex_branch_taken=1 with load-use in ID -> flush_id=1, stall_id=0, flush_cnt=1, stall_cnt=0.
REQ-036 Reset mid-operation: assert reset asynchronously between edges with all stages valid -> stg_valid=0 and counters=0 immediately; NSTAGES=5 rerun of REQ-032 with 5-edge latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline control unit: stage entry and forward-select encoding.
package pipe_pkg;
  localparam int REG_AW     = 5;
  // Stage entries carry the widest control word any instance may use; the top
  // zero-extends its CTRL_W word into it and unused upper bits are pruned.
  localparam int CTRL_MAX_W = 64;
  localparam int FWD_W      = 3;

  typedef logic [FWD_W-1:0] fwd_sel_t;

  typedef struct packed {
    logic [CTRL_MAX_W-1:0] ctrl;
    logic                  valid;
    logic [REG_AW-1:0]     rd;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  is_load;
  } stage_t;
endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage entry; a bubble load clears it exactly like reset does.
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_bubble,
  input  stage_t d,
  output stage_t q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            q <= '0;
    else if (load_bubble) q <= '0;
    else                  q <= d;
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: stage shift register, load-use stall, branch flush,
// EX operand forwarding select and stall/flush event counters.
module pipe_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = 16,
  parameter int NSTAGES = 3,
  parameter int RW_BIT  = 0,
  localparam int SEL_W  = $clog2(NSTAGES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic [CTRL_W-1:0]              id_ctrl,
  input  logic [REG_AW-1:0]              id_rs1,
  input  logic [REG_AW-1:0]              id_rs2,
  input  logic [REG_AW-1:0]              id_rd,
  input  logic                           id_use_rs1,
  input  logic                           id_use_rs2,
  input  logic                           id_is_load,
  input  logic                           ex_branch_taken,
  output logic [NSTAGES-1:0][CTRL_W-1:0] stg_ctrl,
  output logic [NSTAGES-1:0]             stg_valid,
  output logic [NSTAGES-1:0][REG_AW-1:0] stg_rd,
  output logic                           stall_id,
  output logic                           flush_id,
  output logic [SEL_W-1:0]               fwd_a,
  output logic [SEL_W-1:0]               fwd_b,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    flush_cnt
);
  stage_t   id_e;
  stage_t   stg_q [NSTAGES];
  stage_t   ex;
  logic     hazard, flush_raw, ex_bubble;
  fwd_sel_t sel_a, sel_b;

  always_comb begin
    id_e                 = '0;
    id_e.ctrl[CTRL_W-1:0] = id_ctrl;
    id_e.valid           = id_valid;
    id_e.rd              = id_rd;
    id_e.rs1             = id_rs1;
    id_e.rs2             = id_rs2;
    id_e.use_rs1         = id_use_rs1;
    id_e.use_rs2         = id_use_rs2;
    id_e.is_load         = id_is_load;
  end

  // stg_q[0] is EX (stage 1), stg_q[NSTAGES-1] is WB.
  for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
    logic unused_bits;
    if (g == 0) begin : g_ex
      pipe_stage_reg u_reg (.clk(clk), .reset(reset), .load_bubble(ex_bubble),
                            .d(id_e), .q(stg_q[g]));
    end else begin : g_tail
      pipe_stage_reg u_reg (.clk(clk), .reset(reset), .load_bubble(1'b0),
                            .d(stg_q[g-1]), .q(stg_q[g]));
    end
    assign stg_ctrl[g]  = stg_q[g].ctrl[CTRL_W-1:0];
    assign stg_valid[g] = stg_q[g].valid;
    assign stg_rd[g]    = stg_q[g].rd;
    assign unused_bits  = ^stg_q[g];
  end

  assign ex = stg_q[0];

  assign hazard = id_valid & ex.valid & ex.is_load & (ex.rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex.rd)) | (id_use_rs2 & (id_rs2 == ex.rd)));
  assign flush_raw = ex_branch_taken & ex.valid;
  assign ex_bubble = hazard | flush_raw;

  // Flush wins over stall: the instruction being held is on the wrong path anyway.
  assign stall_id = hazard & ~flush_raw & ~reset;
  assign flush_id = flush_raw & ~reset;

  // Walk from WB toward EX so the youngest (lowest-numbered) producer wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = NSTAGES - 1; k >= 1; k--) begin
      if (stg_q[k].valid && stg_q[k].ctrl[RW_BIT] && stg_q[k].rd != '0 && ex.valid) begin
        if (ex.use_rs1 && stg_q[k].rd == ex.rs1) sel_a = fwd_sel_t'(k);
        if (ex.use_rs2 && stg_q[k].rd == ex.rs2) sel_b = fwd_sel_t'(k);
      end
    end
  end

  assign fwd_a = reset ? '0 : sel_a[SEL_W-1:0];
  assign fwd_b = reset ? '0 : sel_b[SEL_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_id) stall_cnt <= stall_cnt + 32'd1;
      if (flush_id) flush_cnt <= flush_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: 3-stage instance checked every cycle against a
// behavioural model, plus directed literal checks on a 3- and 5-stage instance.
module tb_pipe_ctrl_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid, id_use_rs1, id_use_rs2, id_is_load, ex_branch_taken;
  logic [15:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic [2:0][15:0] c3;  logic [2:0] v3;  logic [2:0][4:0] rd3;
  logic st3, fl3;  logic [1:0] fa3, fb3;  logic [31:0] sc3, fc3;
  logic [4:0][15:0] c5;  logic [4:0] v5;  logic [4:0][4:0] rd5;
  logic st5, fl5;  logic [2:0] fa5, fb5;  logic [31:0] sc5, fc5;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.CTRL_W(16), .NSTAGES(3), .RW_BIT(0)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .stg_ctrl(c3), .stg_valid(v3), .stg_rd(rd3),
    .stall_id(st3), .flush_id(fl3), .fwd_a(fa3), .fwd_b(fb3),
    .stall_cnt(sc3), .flush_cnt(fc3));

  pipe_ctrl_unit #(.CTRL_W(16), .NSTAGES(5), .RW_BIT(0)) dut5 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .stg_ctrl(c5), .stg_valid(v5), .stg_rd(rd5),
    .stall_id(st5), .flush_id(fl5), .fwd_a(fa5), .fwd_b(fb5),
    .stall_cnt(sc5), .flush_cnt(fc5));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 3-stage instance ----------------
  typedef struct {
    logic        v;
    logic [15:0] c;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, ld;
  } ent_t;

  ent_t        m [1:3];
  logic [31:0] msc, mfc;

  function automatic ent_t bubble();
    ent_t e;
    e.v = 1'b0; e.c = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
    e.u1 = 1'b0; e.u2 = 1'b0; e.ld = 1'b0;
    return e;
  endfunction

  function automatic ent_t from_id();
    ent_t e;
    e.v = id_valid; e.c = id_ctrl; e.rd = id_rd; e.rs1 = id_rs1; e.rs2 = id_rs2;
    e.u1 = id_use_rs1; e.u2 = id_use_rs2; e.ld = id_is_load;
    return e;
  endfunction

  function automatic logic m_hazard();
    return id_valid && m[1].v && m[1].ld && m[1].rd != 0 &&
           ((id_use_rs1 && id_rs1 == m[1].rd) || (id_use_rs2 && id_rs2 == m[1].rd));
  endfunction

  function automatic logic m_flush();
    return ex_branch_taken && m[1].v;
  endfunction

  // Nearest writer older than EX that produces the register EX needs.
  function automatic int m_fwd(input logic [4:0] rs, input logic use_f);
    if (!m[1].v || !use_f) return 0;
    for (int k = 2; k <= 3; k++)
      if (m[k].v && m[k].c[0] && m[k].rd != 0 && m[k].rd == rs) return k - 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= 3; k++) m[k] <= bubble();
      msc <= '0;
      mfc <= '0;
    end else begin
      m[3] <= m[2];
      m[2] <= m[1];
      m[1] <= (m_hazard() || m_flush()) ? bubble() : from_id();
      if (m_flush())       mfc <= mfc + 1;
      else if (m_hazard()) msc <= msc + 1;
    end
  end

  always @(negedge clk) begin
    for (int k = 1; k <= 3; k++) begin
      chk("stg_valid", 32'(v3[k-1]), 32'(m[k].v));
      chk("stg_ctrl",  32'(c3[k-1]), 32'(m[k].c));
      chk("stg_rd",    32'(rd3[k-1]), 32'(m[k].rd));
    end
    chk("stall_id",  32'(st3), 32'(!reset && m_hazard() && !m_flush()));
    chk("flush_id",  32'(fl3), 32'(!reset && m_flush()));
    chk("fwd_a",     32'(fa3), reset ? 32'd0 : 32'(m_fwd(m[1].rs1, m[1].u1)));
    chk("fwd_b",     32'(fb3), reset ? 32'd0 : 32'(m_fwd(m[1].rs2, m[1].u2)));
    chk("stall_cnt", sc3, msc);
    chk("flush_cnt", fc3, mfc);
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic v, input logic [15:0] c, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic ld, input logic br);
    id_valid = v; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_is_load = ld; ex_branch_taken = br;
  endtask

  task automatic idle();
    set_in(1'b0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset between edges and checks the clear is immediate.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_valid3", 32'(v3), 32'd0);
    chk("rst_valid5", 32'(v5), 32'd0);
    chk("rst_scnt",   sc3, 32'd0);
    chk("rst_fcnt",   fc3, 32'd0);
    chk("rst_stall",  32'(st3), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    tick(2);
    reset = 1'b0;
    chk("reset_valid", 32'(v3), 32'd0);
    chk("reset_fwd",   32'(fa3), 32'd0);

    // Plain flow: latency equals stage count.
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("flow3_early", 32'(v3[2]), 32'd0);
    tick(1);
    chk("flow3_valid", 32'(v3[2]), 32'd1);
    chk("flow3_ctrl",  32'(c3[2]), 32'h0001);
    chk("flow3_rd",    32'(rd3[2]), 32'd5);
    chk("model_flow_rd", 32'(m[3].rd), 32'd5);
    chk("flow3_nostall", sc3, 32'd0);
    tick(1);
    chk("flow5_early", 32'(v5[4]), 32'd0);
    tick(1);
    chk("flow5_valid", 32'(v5[4]), 32'd1);
    chk("flow5_ctrl",  32'(c5[4]), 32'h0001);
    chk("flow5_rd",    32'(rd5[4]), 32'd5);
    chk("flow5_noflush", fc5, 32'd0);
    idle();
    do_reset();

    // Load-use: one stall cycle, then forward from WB.
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    set_in(1'b1, 16'h0001, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_stall", 32'(st3), 32'd1);
    chk("model_lu_hazard", 32'(m_hazard()), 32'd1);
    tick(1);
    chk("lu_bubble", 32'(v3[0]), 32'd0);
    chk("lu_cnt", sc3, 32'd1);
    chk("lu_stall_gone", 32'(st3), 32'd0);
    tick(1);
    chk("lu_add_ex", 32'(rd3[0]), 32'd8);
    chk("lu_fwd_a", 32'(fa3), 32'd2);
    idle();
    do_reset();

    // Forwarding priority: nearest writer wins; rd=0 never forwards.
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    set_in(1'b1, 16'h0000, 5'd0, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    idle();
    #1 chk("fwd_b_nearest", 32'(fb3), 32'd1);
    chk("model_fwd_b", 32'(m_fwd(m[1].rs2, m[1].u2)), 32'd1);
    tick(3);
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    set_in(1'b1, 16'h0000, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    idle();
    #1 chk("fwd_b_rd0", 32'(fb3), 32'd0);
    tick(3);
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    set_in(1'b1, 16'h0000, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    set_in(1'b1, 16'h0000, 5'd0, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    idle();
    #1 chk("fwd_b_wb_only", 32'(fb3), 32'd2);
    tick(3);

    // Branch with an empty EX stage is ignored.
    set_in(1'b0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk("br_ignored", 32'(fl3), 32'd0);
    tick(1);
    chk("br_ignored_cnt", fc3, 32'd0);
    idle();
    do_reset();

    // Branch and load-use in the same cycle: flush wins.
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    set_in(1'b1, 16'h0001, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk("bh_flush", 32'(fl3), 32'd1);
    chk("bh_stall", 32'(st3), 32'd0);
    tick(1);
    chk("bh_fcnt", fc3, 32'd1);
    chk("bh_scnt", sc3, 32'd0);
    chk("bh_bubble", 32'(v3[0]), 32'd0);
    chk("bh_branch_kept", 32'(v3[1]), 32'd1);

    // Full pipeline, then asynchronous reset between edges.
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    chk("full_valid", 32'(v3), 32'h7);
    chk("full_fcnt", fc3, 32'd1);
    do_reset();

    // Reset in the middle of a stall; first edge afterwards loads ID normally.
    set_in(1'b1, 16'h0001, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    set_in(1'b1, 16'h0001, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("mid_stall", 32'(st3), 32'd1);
    do_reset();
    tick(1);
    chk("post_rst_valid", 32'(v3[0]), 32'd1);
    chk("post_rst_rd",    32'(rd3[0]), 32'd8);
    chk("post_rst_scnt",  sc3, 32'd0);
    idle();
    tick(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
